// File: rtl/blink_pkg.sv
// Shared types and default parameters for the blink receive-side monitor.
package blink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_STUCK   = 2'd3
    } state_e;

    localparam int unsigned DEF_CNT_W    = 8;
    localparam int unsigned DEF_TIMEOUT  = 200;
    localparam int unsigned DEF_FILT_LEN = 3;

endpackage

// File: rtl/blink_monitor_if.sv
// Blink link bundle: the raw blink input plus the monitor's status outputs.
interface blink_monitor_if
    import blink_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
);
    logic             din;
    logic             level;
    logic             edge_pulse;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             stuck;

    modport master (
        output din,
        input  level, edge_pulse, half_period, period_valid, stuck
    );

    modport slave (
        input  din,
        output level, edge_pulse, half_period, period_valid, stuck
    );
endinterface

// File: rtl/blink_sync.sv
// 2-FF synchronizer and edge detector for the blink input.
// BLINK_MON_GLITCH_FILTER_EN adds a stability filter of FILT_LEN cycles before a level change is accepted.
module blink_sync
    import blink_pkg::*;
`ifdef BLINK_MON_GLITCH_FILTER_EN
#(
    parameter int unsigned FILT_LEN = DEF_FILT_LEN
)
`endif
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_din,
    output logic o_level,
    output logic o_edge_c
);

    logic r_s1;
    logic r_s2;
    logic r_level;
    logic w_edge;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_din;
            r_s2 <= r_s1;
        end
    end

`ifdef BLINK_MON_GLITCH_FILTER_EN
    localparam int unsigned FC_W = $clog2(FILT_LEN + 1);

    logic [FC_W-1:0] r_fcnt;
    logic            w_diff;

    // Accept only after FILT_LEN earlier cycles of disagreement, so a clean edge is delayed by exactly FILT_LEN.
    assign w_diff = r_s2 ^ r_level;
    assign w_edge = w_diff && (r_fcnt == FC_W'(FILT_LEN));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fcnt  <= '0;
            r_level <= 1'b0;
        end else begin
            if (!w_diff || w_edge) begin
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + FC_W'(1);
            end
            if (w_edge) begin
                r_level <= r_s2;
            end
        end
    end
`else
    assign w_edge = r_s2 ^ r_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level <= 1'b0;
        end else begin
            r_level <= r_s2;
        end
    end
`endif

    assign o_level  = r_level;
    assign o_edge_c = w_edge;

endmodule

// File: rtl/blink_monitor.sv
// Blink receive monitor: measures half-period between accepted edges and flags a stuck line.
// Optional glitch filter enabled by BLINK_MON_GLITCH_FILTER_EN.
module blink_monitor
    import blink_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
    parameter int unsigned FILT_LEN = DEF_FILT_LEN
)(
    input  logic            clock,
    input  logic            r,
    blink_monitor_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    generate
        if (TIMEOUT < 2 || TIMEOUT > (2**CNT_W) - 1 || FILT_LEN < 1) begin : g_bad_param
            $error("blink_monitor: TIMEOUT or FILT_LEN out of range");
        end
    endgenerate

    logic             w_level;
    logic             w_edge;
    logic [CNT_W-1:0] r_cnt;
    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_edge_pulse;
    logic [CNT_W-1:0] r_half_period;
    logic [CNT_W-1:0] w_hp_nxt;
    logic             r_period_valid;
    logic             w_pv_nxt;
    logic             r_stuck;
    logic             w_stuck_nxt;

    blink_sync
`ifdef BLINK_MON_GLITCH_FILTER_EN
        #(.FILT_LEN(FILT_LEN))
`endif
    u_sync (
        .i_clk    (clock),
        .i_rst_n  (r),
        .i_din    (bus.din),
        .o_level  (w_level),
        .o_edge_c (w_edge)
    );

    // Cycles since the last accepted edge; restarts at 1 so it equals the edge spacing.
    always_ff @(posedge clock or negedge r) begin
        if (!r) begin
            r_cnt <= '0;
        end else if (w_edge) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge r) begin
        if (!r) begin
            r_state        <= ST_IDLE;
            r_edge_pulse   <= 1'b0;
            r_half_period  <= '0;
            r_period_valid <= 1'b0;
            r_stuck        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_edge_pulse   <= w_edge;
            r_half_period  <= w_hp_nxt;
            r_period_valid <= w_pv_nxt;
            r_stuck        <= w_stuck_nxt;
        end
    end

    // An edge always takes priority over the timeout in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_hp_nxt    = r_half_period;
        w_pv_nxt    = 1'b0;
        w_stuck_nxt = r_stuck;
        if (w_edge) begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_MEASURE;
                end
                ST_MEASURE, ST_LOCKED: begin
                    w_state_nxt = ST_LOCKED;
                    w_hp_nxt    = r_cnt;
                    w_pv_nxt    = 1'b1;
                end
                ST_STUCK: begin
                    w_state_nxt = ST_MEASURE;
                    w_stuck_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else if (r_cnt == TIMEOUT_C) begin
            w_state_nxt = ST_STUCK;
            w_stuck_nxt = 1'b1;
        end
    end

    assign bus.level        = w_level;
    assign bus.edge_pulse   = r_edge_pulse;
    assign bus.half_period  = r_half_period;
    assign bus.period_valid = r_period_valid;
    assign bus.stuck        = r_stuck;

endmodule

// File: tb/tb_blink_monitor.sv
// Scoreboard bench for blink_monitor: expected half-periods are queued as din is toggled.
module tb_blink_monitor;
    import blink_pkg::*;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned TIMEOUT  = 100;
    localparam int unsigned FILT_LEN = 3;

    logic clock = 1'b0;
    logic r     = 1'b0;
    always #5 clock = ~clock;

    blink_monitor_if #(.CNT_W(CNT_W)) bus ();

    blink_monitor #(
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .FILT_LEN (FILT_LEN)
    ) dut (
        .clock (clock),
        .r     (r),
        .bus   (bus)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    int unsigned cyc     = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [CNT_W-1:0] exp_q[$];
    int unsigned n_pulse = 0, n_pv = 0, n_stuck = 0;
    int unsigned last_pulse = 0, rel_cyc = 0;
    bit          pulse_seen = 0;
    logic        stuck_d    = 1'b0;

    // Bench-side model: a queued value is expected only when a reference edge exists and the gap did not time out.
    bit          m_ref   = 0;
    int unsigned m_gap   = 0;
    int unsigned n_flip  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (r) begin
            if (bus.edge_pulse) begin
                n_pulse++;
                last_pulse = cyc;
                pulse_seen = 1;
            end
            if (bus.period_valid) begin
                n_pv++;
                chk("pv_while_stuck", 32'(bus.stuck), 32'd0);
                chk("pv_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("half_period", 32'(bus.half_period), 32'(exp_q.pop_front()));
            end
            if (bus.stuck && !stuck_d) begin
                n_stuck++;
                if (pulse_seen) chk("stuck_after_edge", cyc - last_pulse, TIMEOUT);
                else            chk("stuck_after_reset", cyc - rel_cyc, TIMEOUT + 1);
            end
            stuck_d = bus.stuck;
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clock);
        m_gap += n;
    endtask

    task automatic flip_after(input int unsigned gap);
        repeat (gap) @(negedge clock);
        m_gap += gap;
        bus.din = ~bus.din;
        n_flip++;
        if (m_ref && m_gap <= TIMEOUT) exp_q.push_back(CNT_W'(m_gap));
        m_ref = 1;
        m_gap = 0;
    endtask

    task automatic glitch();
`ifdef BLINK_MON_GLITCH_FILTER_EN
        bus.din = ~bus.din;
        @(negedge clock);
        bus.din = ~bus.din;
        m_gap += 1;
`else
        flip_after(0);
        flip_after(1);
`endif
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_level"},  32'(bus.level),        32'd0);
        chk({tag, "_edge"},   32'(bus.edge_pulse),   32'd0);
        chk({tag, "_hp"},     32'(bus.half_period),  32'd0);
        chk({tag, "_pv"},     32'(bus.period_valid), 32'd0);
        chk({tag, "_stuck"},  32'(bus.stuck),        32'd0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        #1;
        r          = 1'b1;
        rel_cyc    = cyc;
        pulse_seen = 0;
        stuck_d    = 1'b0;
        m_gap      = 0;
        m_ref      = 0;
    endtask

    int unsigned pv_snap, pulse_snap;

    initial begin
        bus.din = 1'b0;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        release_reset();

        // No edges at all: stuck timing from reset release is checked by the monitor.
        idle(TIMEOUT + 10);
        chk("stuck_from_reset_count", n_stuck, 1);

        repeat (8) flip_after(10);
        repeat (4) flip_after(25);
        repeat (6) flip_after(7);
        idle(10);
        chk("toggle_stuck_low", 32'(bus.stuck), 32'd0);
        chk("toggle_pulses", n_pulse, n_flip);

        // Long hold: stuck, then the first edge only re-arms the measurement.
        idle(150);
        chk("hold_stuck_count", n_stuck, 2);
        chk("hold_stuck_level", 32'(bus.stuck), 32'd1);
        pv_snap = n_pv;
        flip_after(5);
        idle(10);
        chk("stuck_cleared", 32'(bus.stuck), 32'd0);
        chk("stuck_exit_no_pv", n_pv - pv_snap, 0);
        flip_after(10);

        // Edge exactly at cnt==TIMEOUT wins; one cycle later it does not.
        flip_after(TIMEOUT);
        idle(10);
        chk("edge_at_timeout_no_stuck", n_stuck, 2);
        flip_after(TIMEOUT + 1 - 10);
        flip_after(10);
        idle(10);
        chk("edge_after_timeout_stuck", n_stuck, 3);

        flip_after(12);
        idle(20);
        pulse_snap = n_pulse;
        glitch();
        idle(15);
`ifdef BLINK_MON_GLITCH_FILTER_EN
        chk("glitch_pulses", n_pulse - pulse_snap, 0);
`else
        chk("glitch_pulses", n_pulse - pulse_snap, 2);
`endif
        flip_after(15);

        // Bring din low, then reset asynchronously mid-period.
        if (bus.din) flip_after(10);
        flip_after(10);
        flip_after(10);
        idle(5);
        chk("pre_reset_queue", 32'(exp_q.size()), 32'd0);
        @(negedge clock);
        #2;
        r = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        repeat (3) @(negedge clock);
        release_reset();

        pv_snap = n_pv;
        flip_after(30);
        idle(10);
        chk("post_reset_first_edge_no_pv", n_pv - pv_snap, 0);
        flip_after(12);
        idle(20);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_pulses", n_pulse, n_flip);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
